led_chaser_gen: RTL



---
 rtl/led_chaser_gen.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/led_chaser_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_chaser_gen
// Description : LED "running point" pattern generator. A free-running
//               prescaler feeds a selectable tap. Each rising edge of that tap
//               advances the LED pattern. Debounced buttons step the rate and
//               the mode. A pause level freezes the pattern. Modes are
//               SHIFT_L, SHIFT_R, BOUNCE and FILL.
//               Defining CHASER_LFSR_EN adds mode 4 (RANDOM). That mode is
//               driven by a 16-bit Fibonacci LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module led_chaser_gen #(
    parameter int N_LEDS   = 18,
    parameter int PRESC_W  = 26,
    parameter int RATE_MAX = 25,
    parameter int RATE_MIN = 15
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       rate_step,
    input  logic                       mode_step,
    input  logic                       pause,
    output logic [N_LEDS-1:0]          leds,
    output logic                       tick,
    output logic [$clog2(PRESC_W)-1:0] rate_sel,
    output logic [2:0]                 mode
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                  c_sel_w     = $clog2(PRESC_W);
    localparam logic [c_sel_w-1:0]  c_rate_max  = c_sel_w'(RATE_MAX);
    localparam logic [c_sel_w-1:0]  c_rate_min  = c_sel_w'(RATE_MIN);
    localparam logic [c_sel_w-1:0]  c_sel_one   = c_sel_w'(1);
    localparam logic [PRESC_W-1:0]  c_presc_one = PRESC_W'(1);
    localparam logic [N_LEDS-1:0]   c_led_first = N_LEDS'(1);
    localparam logic [N_LEDS-1:0]   c_led_last  = c_led_first << (N_LEDS - 1);
    localparam logic                c_dir_up    = 1'b0;
    localparam logic                c_dir_down  = 1'b1;
`ifdef CHASER_LFSR_EN
    localparam logic [15:0]         c_lfsr_seed = 16'hACE1;
`endif

    // The mode register is the state of the pattern FSM.
    typedef enum logic [2:0] {
        MODE_SHIFT_L = 3'd0,
        MODE_SHIFT_R = 3'd1,
        MODE_BOUNCE  = 3'd2,
`ifdef CHASER_LFSR_EN
        MODE_FILL    = 3'd3,
        MODE_RANDOM  = 3'd4
`else
        MODE_FILL    = 3'd3
`endif
    } mode_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
`ifdef CHASER_LFSR_EN
    // LED i mirrors LFSR bit (i mod 16), so banks wider than 16 repeat.
    function automatic logic [N_LEDS-1:0] lfsr_to_leds(input logic [15:0] l);
        logic [N_LEDS-1:0] p;
        p = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            p[i] = l[i % 16];
        end
        return p;
    endfunction
`endif

    // Pattern shown on entry to a mode, and after an all-dark recovery.
    function automatic logic [N_LEDS-1:0] init_pattern(input mode_t m);
        logic [N_LEDS-1:0] p;
        p = c_led_first;
        case (m)
            MODE_SHIFT_L: p = c_led_first;
            MODE_SHIFT_R: p = c_led_last;
            MODE_BOUNCE:  p = c_led_first;
            MODE_FILL:    p = '0;
`ifdef CHASER_LFSR_EN
            MODE_RANDOM:  p = lfsr_to_leds(c_lfsr_seed);
`endif
            default:      p = c_led_first;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] r_presc;
    logic               r_tap_prev;
    logic               r_rate_prev;
    logic               r_mode_prev;
    logic [c_sel_w-1:0] r_rate_sel;
    mode_t              r_mode;
    logic [N_LEDS-1:0]  r_leds;
    logic               r_dir;
    logic               r_tick;
`ifdef CHASER_LFSR_EN
    logic [15:0]        r_lfsr;
`endif

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_tap;
    logic               w_step;
    logic               w_rate_edge;
    logic               w_mode_edge;
    logic [c_sel_w-1:0] w_rate_next;
    logic               w_tap_prev_next;
    mode_t              w_mode_next;
    logic [N_LEDS-1:0]  w_leds_next;
    logic               w_dir_next;
    logic               w_tick_next;
    logic               w_need_reload;
    logic [N_LEDS-1:0]  w_shift_l;
    logic [N_LEDS-1:0]  w_shift_r;
    logic [N_LEDS-1:0]  w_bounce_up;
    logic [N_LEDS-1:0]  w_bounce_dn;
    logic [N_LEDS-1:0]  w_fill;
`ifdef CHASER_LFSR_EN
    logic [15:0]        w_lfsr_shift;
    logic [15:0]        w_lfsr_next;
`endif

    // The step event is a rising edge of the selected prescaler bit.
    assign w_tap       = r_presc[r_rate_sel];
    assign w_step      = w_tap & ~r_tap_prev;
    assign w_rate_edge = rate_step & ~r_rate_prev;
    assign w_mode_edge = mode_step & ~r_mode_prev;

    // Candidate next patterns for each mode.
    assign w_shift_l   = {r_leds[N_LEDS-2:0], r_leds[N_LEDS-1]};
    assign w_shift_r   = {r_leds[0], r_leds[N_LEDS-1:1]};
    assign w_bounce_up = r_leds << 1;
    assign w_bounce_dn = r_leds >> 1;
    assign w_fill      = (r_leds == '1) ? '0 : {r_leds[N_LEDS-2:0], 1'b1};
`ifdef CHASER_LFSR_EN
    // Taps 16,14,13,11 map to bits 15,13,12,10.
    assign w_lfsr_shift = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
`endif

    // A dark bank in a single-point mode can only come from an upset.
    // It is recovered by reloading the mode's start pattern.
    assign w_need_reload = (r_leds == '0) &&
                           (r_mode inside {MODE_SHIFT_L, MODE_SHIFT_R, MODE_BOUNCE});

    // Rate stepping walks from slow to fast, then wraps to slowest. On a
    // change the tap history is loaded from the new tap. The first
    // comparison on the new tap then cannot produce a false edge.
    always_comb begin
        w_rate_next     = r_rate_sel;
        w_tap_prev_next = w_tap;
        if (w_rate_edge) begin
            if (r_rate_sel == c_rate_min) begin
                w_rate_next = c_rate_max;
            end else begin
                w_rate_next = r_rate_sel - c_sel_one;
            end
            w_tap_prev_next = r_presc[w_rate_next];
        end
    end

    // Prescaler, button edge history and rate selection.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_presc     <= '0;
            r_tap_prev  <= 1'b0;
            r_rate_prev <= 1'b0;
            r_mode_prev <= 1'b0;
            r_rate_sel  <= c_rate_max;
        end else begin
            r_presc     <= r_presc + c_presc_one;
            r_tap_prev  <= w_tap_prev_next;
            r_rate_prev <= rate_step;
            r_mode_prev <= mode_step;
            r_rate_sel  <= w_rate_next;
        end
    end

    // Next mode and pattern. Priority: mode change, then recovery, then step.
    // A mode change swallows a coincident step, so tick stays low.
    always_comb begin
        w_mode_next = r_mode;
        w_leds_next = r_leds;
        w_dir_next  = r_dir;
        w_tick_next = 1'b0;
`ifdef CHASER_LFSR_EN
        w_lfsr_next = r_lfsr;
`endif
        if (w_mode_edge) begin
            case (r_mode)
                MODE_SHIFT_L: w_mode_next = MODE_SHIFT_R;
                MODE_SHIFT_R: w_mode_next = MODE_BOUNCE;
                MODE_BOUNCE:  w_mode_next = MODE_FILL;
`ifdef CHASER_LFSR_EN
                MODE_FILL:    w_mode_next = MODE_RANDOM;
`else
                MODE_FILL:    w_mode_next = MODE_SHIFT_L;
`endif
                default:      w_mode_next = MODE_SHIFT_L;
            endcase
            w_leds_next = init_pattern(w_mode_next);
            w_dir_next  = c_dir_up;
`ifdef CHASER_LFSR_EN
            if (w_mode_next == MODE_RANDOM) begin
                w_lfsr_next = c_lfsr_seed;
            end
`endif
        end else if (w_need_reload) begin
            w_leds_next = init_pattern(r_mode);
            w_dir_next  = c_dir_up;
        end else if (w_step && !pause) begin
            w_tick_next = 1'b1;
            case (r_mode)
                MODE_SHIFT_L: w_leds_next = w_shift_l;
                MODE_SHIFT_R: w_leds_next = w_shift_r;
                MODE_BOUNCE: begin
                    // The direction flips as soon as an end LED is lit,
                    // so an end LED is shown for one step only.
                    if (r_dir == c_dir_up) begin
                        w_leds_next = w_bounce_up;
                        if (w_bounce_up[N_LEDS-1]) begin
                            w_dir_next = c_dir_down;
                        end
                    end else begin
                        w_leds_next = w_bounce_dn;
                        if (w_bounce_dn[0]) begin
                            w_dir_next = c_dir_up;
                        end
                    end
                end
                MODE_FILL:    w_leds_next = w_fill;
`ifdef CHASER_LFSR_EN
                MODE_RANDOM: begin
                    w_lfsr_next = w_lfsr_shift;
                    w_leds_next = lfsr_to_leds(w_lfsr_shift);
                end
`endif
                default:      w_leds_next = r_leds;
            endcase
        end
    end

    // Mode / pattern state register; tick is registered alongside leds.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_SHIFT_L;
            r_leds <= c_led_first;
            r_dir  <= c_dir_up;
            r_tick <= 1'b0;
`ifdef CHASER_LFSR_EN
            r_lfsr <= c_lfsr_seed;
`endif
        end else begin
            r_mode <= w_mode_next;
            r_leds <= w_leds_next;
            r_dir  <= w_dir_next;
            r_tick <= w_tick_next;
`ifdef CHASER_LFSR_EN
            r_lfsr <= w_lfsr_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign leds     = r_leds;
    assign tick     = r_tick;
    assign rate_sel = r_rate_sel;
    assign mode     = r_mode;

endmodule
`default_nettype wire
